// File: rtl/qsys_ram_loader_pkg.sv
// Shared types and helpers for the boot-copy RAM loader.
// State encoding, lane count, default widths and the byteenable mask builder.
package qsys_ram_loader_pkg;

   localparam int LANES      = 4;
   localparam int ADDR_W_DEF = 12;
   localparam int CNT_W_DEF  = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Contiguous enables for lanes 0..last_lane (tail words are never sparse).
   function automatic logic [LANES-1:0] lane_mask(input logic [1:0] last_lane);
      logic [LANES-1:0] m;
      case (last_lane)
         2'd0:    m = 4'h1;
         2'd1:    m = 4'h3;
         2'd2:    m = 4'h7;
         default: m = 4'hF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/qsys_ram_loader_pack.sv
// Little-endian byte-to-word packer for the RAM loader.
// Collects up to four bytes, tracks filled lanes, flags when a word must be written.
module qsys_ram_loader_pack
   import qsys_ram_loader_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clr,
   input  logic                 push,
   input  logic [7:0]           push_data,
   input  logic                 push_last,
   output logic [8*LANES-1:0]   word,
   output logic [LANES-1:0]     mask,
   output logic                 word_ready
);

   logic [1:0] lane;

   // Clearing after every write keeps unfilled lanes of a tail word at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lane <= '0;
         word <= '0;
         mask <= '0;
      end else if (clr) begin
         lane <= '0;
         word <= '0;
         mask <= '0;
      end else if (push) begin
         word[{lane, 3'b000} +: 8] <= push_data;
         mask                      <= lane_mask(lane);
         lane                      <= lane + 2'd1;
      end
   end

   assign word_ready = push & ((lane == 2'd3) | push_last);

endmodule

// File: rtl/qsys_ram_loader.sv
// Boot-copy loader: streams bytes into the system RAM and holds the CPU in reset until done.
// Optional running word checksum output enabled by defining QSYS_RAM_LOADER_CSUM_EN.
module qsys_ram_loader
   import qsys_ram_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
)
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [CNT_W-1:0]    byte_count,
   input  logic [7:0]          st_data,
   input  logic                st_valid,
   output logic                st_ready,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [3:0]          ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [31:0]         ram_writedata,
   output logic                ram_clken,
   output logic                cpu_reset_req,
   output logic                busy,
   output logic                done,
   output logic                error
`ifdef QSYS_RAM_LOADER_CSUM_EN
   ,
   output logic [31:0]         csum
`endif
);

   localparam int SUM_W = CNT_W + 1;
   localparam logic [SUM_W-1:0] IMG_LIMIT = SUM_W'(LANES << ADDR_W);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   word_idx;
   logic [CNT_W-1:0]    remain;
   logic [SUM_W-1:0]    img_end;
   logic                error_q;
   logic                start_ok;
   logic                range_err;
   logic                push;
   logic                push_last;
   logic                word_ready;
   logic                wr_en;
   logic [31:0]         pk_word;
   logic [3:0]          pk_mask;

   // One extra bit so an image ending exactly at the top of RAM is not flagged.
   assign img_end   = SUM_W'({base_addr, 2'b00}) + SUM_W'(byte_count);
   assign range_err = img_end > IMG_LIMIT;
   assign start_ok  = (state == IDLE) && start;
   assign push      = (state == FILL) && st_valid;
   assign push_last = (remain == CNT_W'(1));
   assign wr_en     = (state == WRITE);

   qsys_ram_loader_pack u_pack (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr        (start_ok | wr_en),
      .push       (push),
      .push_data  (st_data),
      .push_last  (push_last),
      .word       (pk_word),
      .mask       (pk_mask),
      .word_ready (word_ready)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_ok && !range_err)
               state_nxt = (byte_count == '0) ? DONE : FILL;
         end
         FILL:    if (word_ready) state_nxt = WRITE;
         WRITE:   state_nxt = (remain == '0) ? DONE : FILL;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      st_ready       = 1'b0;
      ram_write      = 1'b0;
      ram_chipselect = 1'b0;
      ram_address    = '0;
      ram_byteenable = '0;
      ram_writedata  = '0;
      busy           = 1'b0;
      done           = 1'b0;
      case (state)
         FILL: begin
            st_ready = 1'b1;
            busy     = 1'b1;
         end
         WRITE: begin
            ram_write      = 1'b1;
            ram_chipselect = 1'b1;
            ram_address    = base_q + word_idx;
            ram_byteenable = pk_mask;
            ram_writedata  = pk_word;
            busy           = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign cpu_reset_req = busy;
   assign error         = error_q;
   assign ram_clken     = 1'b1;

   // A rejected start only updates the sticky error; the copy context is untouched.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q   <= '0;
         word_idx <= '0;
         remain   <= '0;
         error_q  <= 1'b0;
      end else if (start_ok) begin
         error_q <= range_err;
         if (!range_err) begin
            base_q   <= base_addr;
            remain   <= byte_count;
            word_idx <= '0;
         end
      end else begin
         if (push)  remain   <= remain - CNT_W'(1);
         if (wr_en) word_idx <= word_idx + ADDR_W'(1);
      end
   end

`ifdef QSYS_RAM_LOADER_CSUM_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                   csum <= '0;
      else if (start_ok && !range_err) csum <= '0;
      else if (wr_en)                  csum <= csum + pk_word;
   end
`endif

endmodule

// File: tb/tb_qsys_ram_loader.sv
// Self-checking bench for qsys_ram_loader: directed scenarios plus randomized copies
// compared against a word-packing reference model (checksum checked when QSYS_RAM_LOADER_CSUM_EN is set).
module tb_qsys_ram_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [11:0] base_addr;
   logic [13:0] byte_count;
   logic [7:0]  st_data;
   logic        st_valid;
   logic        st_ready;
   logic [11:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect;
   logic        ram_write;
   logic [31:0] ram_writedata;
   logic        ram_clken;
   logic        cpu_reset_req;
   logic        busy;
   logic        done;
   logic        error;
`ifdef QSYS_RAM_LOADER_CSUM_EN
   logic [31:0] csum;
`endif

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int stray_cs = 0;

   logic [11:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [3:0]  wr_be[$];
   logic [7:0]  byte_q[$];

   qsys_ram_loader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .base_addr      (base_addr),
      .byte_count     (byte_count),
      .st_data        (st_data),
      .st_valid       (st_valid),
      .st_ready       (st_ready),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .ram_clken      (ram_clken),
      .cpu_reset_req  (cpu_reset_req),
      .busy           (busy),
      .done           (done),
      .error          (error)
`ifdef QSYS_RAM_LOADER_CSUM_EN
      ,
      .csum           (csum)
`endif
   );

   always #5 clk = ~clk;

   // Write/done recorder, sampled mid-cycle.
   always @(negedge clk) begin
      if (ram_write) begin
         wr_addr.push_back(ram_address);
         wr_data.push_back(ram_writedata);
         wr_be.push_back(ram_byteenable);
      end
      if (ram_chipselect !== ram_write) stray_cs++;
      if (done === 1'b1) done_cnt++;
   end

   function automatic void clear_mon();
      wr_addr.delete();
      wr_data.delete();
      wr_be.delete();
   endfunction

   task automatic pulse_start(input logic [11:0] b, input logic [13:0] c);
      @(negedge clk);
      base_addr  = b;
      byte_count = c;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic drive_stream(input int n, input int gap_pct, input int stop_after, input int poke_at);
      int   idx;
      int   cyc;
      logic v;
      idx = 0;
      cyc = 0;
      while (idx < n && idx < stop_after && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         v        = ($urandom_range(99) >= gap_pct);
         st_valid = v;
         st_data  = byte_q[idx];
         if (poke_at == idx) begin
            start      = 1'b1;
            base_addr  = 12'h123;
            byte_count = 14'd4;
         end else begin
            start = 1'b0;
         end
         #1;
         if (v && st_ready) idx++;
      end
      @(negedge clk);
      st_valid = 1'b0;
      start    = 1'b0;
      total++;
      if (cyc >= 4000) begin
         bad++;
         $display("FAIL stream_timeout accepted=%0d required=%0d", idx, n);
      end
   endtask

   task automatic wait_done(input int prev);
      int c;
      c = 0;
      while (done_cnt == prev && c < 1000) begin
         @(negedge clk);
         #1;
         c++;
      end
      total++;
      if (done_cnt != prev + 1) begin
         bad++;
         $display("FAIL done_pulse count=%0d required=%0d", done_cnt - prev, 1);
      end
      @(posedge clk);
      #1;
      total++;
      if ({busy, done, cpu_reset_req} !== 3'b000) begin
         bad++;
         $display("FAIL idle_after_done busy/done/creq=%b required=000", {busy, done, cpu_reset_req});
      end
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      start      = 1'b0;
      base_addr  = '0;
      byte_count = '0;
      st_data    = '0;
      st_valid   = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({st_ready, ram_write, ram_chipselect, ram_address, ram_byteenable, ram_writedata,
           cpu_reset_req, busy, done, error} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%0h required=0", {st_ready, ram_write, ram_chipselect,
                  ram_address, ram_byteenable, ram_writedata, cpu_reset_req, busy, done, error});
      end
      total++;
      if (ram_clken !== 1'b1) begin
         bad++;
         $display("FAIL reset_clken got=%b required=1", ram_clken);
      end
      @(negedge clk);
      reset_n  = 1'b1;
      st_valid = 1'b1;
      st_data  = 8'hEE;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({st_ready, busy, ram_write} !== 3'b000) begin
         bad++;
         $display("FAIL idle_no_accept ready/busy/write=%b required=000", {st_ready, busy, ram_write});
      end
      st_valid = 1'b0;
   endtask

   task automatic test_full_words();
      int d0;
      byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      clear_mon();
      d0 = done_cnt;
      pulse_start(12'h000, 14'd8);
      total++;
      if ({busy, cpu_reset_req, st_ready} !== 3'b111) begin
         bad++;
         $display("FAIL full_busy busy/creq/ready=%b required=111", {busy, cpu_reset_req, st_ready});
      end
      drive_stream(8, 0, 8, -1);
      wait_done(d0);
      total++;
      if (wr_addr.size() != 2) begin
         bad++;
         $display("FAIL full_write_count got=%0d required=2", wr_addr.size());
      end else begin
         total++;
         if ({wr_addr[0], wr_data[0], wr_be[0]} !== {12'h000, 32'h04030201, 4'hF}) begin
            bad++;
            $display("FAIL full_w0 got=%h/%h/%h required=000/04030201/f", wr_addr[0], wr_data[0], wr_be[0]);
         end
         total++;
         if ({wr_addr[1], wr_data[1], wr_be[1]} !== {12'h001, 32'h08070605, 4'hF}) begin
            bad++;
            $display("FAIL full_w1 got=%h/%h/%h required=001/08070605/f", wr_addr[1], wr_data[1], wr_be[1]);
         end
      end
`ifdef QSYS_RAM_LOADER_CSUM_EN
      total++;
      if (csum !== 32'h0C0A0806) begin
         bad++;
         $display("FAIL full_csum got=%h required=0c0a0806", csum);
      end
`endif
   endtask

   task automatic test_tail();
      int d0;
      byte_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      clear_mon();
      d0 = done_cnt;
      pulse_start(12'h010, 14'd5);
      drive_stream(5, 30, 5, -1);
      wait_done(d0);
      total++;
      if (wr_addr.size() != 2) begin
         bad++;
         $display("FAIL tail_write_count got=%0d required=2", wr_addr.size());
      end else begin
         total++;
         if ({wr_addr[0], wr_data[0], wr_be[0]} !== {12'h010, 32'h14131211, 4'hF}) begin
            bad++;
            $display("FAIL tail_w0 got=%h/%h/%h required=010/14131211/f", wr_addr[0], wr_data[0], wr_be[0]);
         end
         total++;
         if ({wr_addr[1], wr_data[1], wr_be[1]} !== {12'h011, 32'h00000015, 4'h1}) begin
            bad++;
            $display("FAIL tail_w1 got=%h/%h/%h required=011/00000015/1", wr_addr[1], wr_data[1], wr_be[1]);
         end
      end
   endtask

   task automatic test_range_error();
      clear_mon();
      pulse_start(12'hFFF, 14'd8);
      total++;
      if ({error, busy, cpu_reset_req} !== 3'b100) begin
         bad++;
         $display("FAIL range_flag error/busy/creq=%b required=100", {error, busy, cpu_reset_req});
      end
      st_valid = 1'b1;
      st_data  = 8'hAA;
      repeat (8) @(negedge clk);
      #1;
      st_valid = 1'b0;
      total++;
      if ({wr_addr.size() == 0, busy, st_ready, error} !== 4'b1001) begin
         bad++;
         $display("FAIL range_quiet writes=%0d busy=%b ready=%b error=%b required 0/0/0/1",
                  wr_addr.size(), busy, st_ready, error);
      end
   endtask

   task automatic test_zero_count();
      int d0;
      clear_mon();
      d0 = done_cnt;
      pulse_start(12'h055, 14'd0);
      total++;
      if ({done, busy, error, ram_write} !== 4'b1100) begin
         bad++;
         $display("FAIL zero_done done/busy/error/write=%b required=1100", {done, busy, error, ram_write});
      end
      @(posedge clk);
      #1;
      total++;
      if ({done, busy, wr_addr.size() == 0, done_cnt == d0 + 1} !== 4'b0011) begin
         bad++;
         $display("FAIL zero_end done=%b busy=%b writes=%0d pulses=%0d required 0/0/0/1",
                  done, busy, wr_addr.size(), done_cnt - d0);
      end
   endtask

   task automatic test_busy_start();
      int d0;
      byte_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
      clear_mon();
      d0 = done_cnt;
      pulse_start(12'h200, 14'd8);
      drive_stream(8, 20, 8, 3);
      wait_done(d0);
      repeat (20) @(negedge clk);
      #1;
      total++;
      if (wr_addr.size() != 2 || busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_start_ignored writes=%0d busy=%b required 2/0", wr_addr.size(), busy);
      end else begin
         total++;
         if ({wr_addr[1], wr_data[1]} !== {12'h201, 32'hA7A6A5A4}) begin
            bad++;
            $display("FAIL busy_start_w1 got=%h/%h required=201/a7a6a5a4", wr_addr[1], wr_data[1]);
         end
      end
   endtask

   task automatic test_reset_midcopy();
      int d0;
      byte_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
      clear_mon();
      d0 = done_cnt;
      pulse_start(12'h020, 14'd8);
      drive_stream(8, 0, 6, -1);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      #1;
      total++;
      if ({st_ready, ram_write, ram_chipselect, ram_address, ram_byteenable, ram_writedata,
           cpu_reset_req, busy, done, error, ram_clken} !== 66'd1) begin
         bad++;
         $display("FAIL midreset_outputs busy=%b ready=%b write=%b clken=%b required 0/0/0/1",
                  busy, st_ready, ram_write, ram_clken);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      total++;
      if ({wr_addr.size() == 1, done_cnt == d0, busy} !== 3'b110) begin
         bad++;
         $display("FAIL midreset_effect writes=%0d pulses=%0d busy=%b required 1/0/0",
                  wr_addr.size(), done_cnt - d0, busy);
      end else begin
         total++;
         if ({wr_addr[0], wr_data[0], wr_be[0]} !== {12'h020, 32'h24232221, 4'hF}) begin
            bad++;
            $display("FAIL midreset_w0 got=%h/%h/%h required=020/24232221/f", wr_addr[0], wr_data[0], wr_be[0]);
         end
      end
`ifdef QSYS_RAM_LOADER_CSUM_EN
      total++;
      if (csum !== 32'h0) begin
         bad++;
         $display("FAIL midreset_csum got=%h required=0", csum);
      end
`endif
   endtask

   task automatic test_random();
      int          n, gap, d0, nw;
      logic [11:0] b, ea;
      logic [31:0] ed, exp_sum;
      logic [3:0]  eb;
      for (int it = 0; it < 8; it++) begin
         n   = (it == 0) ? 8 : (it == 1) ? 1 : int'($urandom_range(2, 40));
         b   = (it == 0) ? 12'hFFE : 12'($urandom_range(0, 4085));
         gap = $urandom_range(0, 50);
         byte_q.delete();
         for (int k = 0; k < n; k++) byte_q.push_back(8'($urandom));
         clear_mon();
         d0 = done_cnt;
         pulse_start(b, 14'(n));
         drive_stream(n, gap, n, -1);
         wait_done(d0);
         nw      = (n + 3) / 4;
         exp_sum = '0;
         total++;
         if (wr_addr.size() != nw) begin
            bad++;
            $display("FAIL rand%0d_count got=%0d required=%0d", it, wr_addr.size(), nw);
         end
         for (int w = 0; w < nw; w++) begin
            ed = '0;
            eb = '0;
            for (int k = 0; k < 4; k++) begin
               if (4 * w + k < n) begin
                  ed    = ed | (32'(byte_q[4 * w + k]) << (8 * k));
                  eb[k] = 1'b1;
               end
            end
            exp_sum = exp_sum + ed;
            ea      = b + 12'(w);
            if (w < wr_addr.size()) begin
               total++;
               if ({wr_addr[w], wr_data[w], wr_be[w]} !== {ea, ed, eb}) begin
                  bad++;
                  $display("FAIL rand%0d_w%0d got=%h/%h/%h required=%h/%h/%h", it, w,
                           wr_addr[w], wr_data[w], wr_be[w], ea, ed, eb);
               end
            end
         end
`ifdef QSYS_RAM_LOADER_CSUM_EN
         total++;
         if (csum !== exp_sum) begin
            bad++;
            $display("FAIL rand%0d_csum got=%h required=%h", it, csum, exp_sum);
         end
`endif
      end
      total++;
      if (stray_cs != 0) begin
         bad++;
         $display("FAIL chipselect_without_write cycles=%0d required=0", stray_cs);
      end
   endtask

   initial begin
      test_reset();
      test_full_words();
      test_tail();
      test_range_error();
      test_zero_count();
      test_busy_start();
      test_reset_midcopy();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
